// File: rtl/apb_navi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_navi_ctrl
// Purpose  : APB slave input controller. Synchronises and debounces NUM_CH
//            raw button lines and captures press/release events in sticky
//            W1C flags. It also counts frames from the VGA super-blank
//            strobe and drives a maskable level interrupt.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            paddr/psel/penable/
//            pwrite/pwdata       - APB request (register index = paddr[30:14])
//            pready/prdata/
//            pslverr             - APB response (zero wait, never errors)
//            navi_raw            - raw button levels, asynchronous
//            super_blank         - VGA super-blank level, asynchronous
//            navi_level          - debounced button levels
//            irq                 - interrupt request, registered level
// Map      : 0 LEVEL(RO) 1 EVENT(W1C) 2 IRQ_EN(RW) 3 CTRL(RW)
//            4 FRAME(RO) 5 super_blank sync'd (RO)
// Revision : 1.0 - initial release
// ============================================================================
module apb_navi_ctrl #(
    parameter int NUM_CH   = 5,
    parameter int DB_CNT_W = 16,
    parameter int DB_LIMIT = 50000,
    parameter int FRAME_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic              pready,
    output logic [31:0]       prdata,
    output logic              pslverr,
    input  logic [NUM_CH-1:0] navi_raw,
    input  logic              super_blank,
    output logic [NUM_CH-1:0] navi_level,
    output logic              irq
);

    localparam logic [16:0]         c_idx_level  = 17'd0;
    localparam logic [16:0]         c_idx_event  = 17'd1;
    localparam logic [16:0]         c_idx_irq_en = 17'd2;
    localparam logic [16:0]         c_idx_ctrl   = 17'd3;
    localparam logic [16:0]         c_idx_frame  = 17'd4;
    localparam logic [16:0]         c_idx_sblank = 17'd5;
    localparam logic [DB_CNT_W-1:0] c_db_last    = DB_CNT_W'(DB_LIMIT - 1);

    logic [16:0]        w_idx;
    logic               w_wr, w_wr_event, w_wr_en, w_wr_ctrl;
    logic [NUM_CH-1:0]  r_nav_s1, r_nav_s2;
    logic               r_sb_s1, r_sb_s2, r_sb_d;
    logic               w_sb_rise;
    logic [NUM_CH-1:0]  r_level, w_level_nxt;
    logic [NUM_CH-1:0]  w_set_ch;
    logic [NUM_CH-1:0]  r_ev_ch, w_ev_ch_nxt, r_en_ch, w_en_ch_nxt;
    logic               r_ev_fr, w_ev_fr_nxt, r_en_fr, w_en_fr_nxt;
    logic [1:0]         r_ctrl;
    logic [FRAME_W-1:0] r_frame;
    logic               r_irq;
    logic               w_unused;

    assign w_idx      = paddr[30:14];
    assign w_wr       = psel & penable & pwrite;
    assign w_wr_event = w_wr && (w_idx == c_idx_event);
    assign w_wr_en    = w_wr && (w_idx == c_idx_irq_en);
    assign w_wr_ctrl  = w_wr && (w_idx == c_idx_ctrl);

    assign pready     = psel & penable;
    assign pslverr    = 1'b0;
    assign navi_level = r_level;
    assign irq        = r_irq;

    // Only paddr[30:14] and a few pwdata bits are decoded.
    assign w_unused = &{1'b0, paddr[31], paddr[13:0], pwdata};

    // Two-flop synchronisers; r_sb_d is the previous synchronised value
    // used for super-blank rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nav_s1 <= '0;
            r_nav_s2 <= '0;
            r_sb_s1  <= 1'b0;
            r_sb_s2  <= 1'b0;
            r_sb_d   <= 1'b0;
        end else begin
            r_nav_s1 <= navi_raw;
            r_nav_s2 <= r_nav_s1;
            r_sb_s1  <= super_blank;
            r_sb_s2  <= r_sb_s1;
            r_sb_d   <= r_sb_s2;
        end
    end

    assign w_sb_rise = r_sb_s2 & ~r_sb_d;

    // Per-channel debounce: a new level is accepted only after it has
    // differed from the current level for DB_LIMIT consecutive cycles.
    generate
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
            logic [DB_CNT_W-1:0] r_cnt;
            logic                w_accept;

            assign w_accept        = (r_nav_s2[ch] != r_level[ch]) && (r_cnt == c_db_last);
            assign w_level_nxt[ch] = w_accept ? r_nav_s2[ch] : r_level[ch];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (r_nav_s2[ch] == r_level[ch] || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_CNT_W'(1);
                end
            end
        end
    endgenerate

    // Hardware set is OR-ed after the W1C mask so a coincident set wins.
    assign w_set_ch    = (w_level_nxt & ~r_level & {NUM_CH{r_ctrl[0]}}) |
                         (~w_level_nxt & r_level & {NUM_CH{r_ctrl[1]}});
    assign w_ev_ch_nxt = (r_ev_ch & ~(w_wr_event ? pwdata[NUM_CH-1:0] : '0)) | w_set_ch;
    assign w_ev_fr_nxt = (r_ev_fr & ~(w_wr_event & pwdata[16])) | w_sb_rise;
    assign w_en_ch_nxt = w_wr_en ? pwdata[NUM_CH-1:0] : r_en_ch;
    assign w_en_fr_nxt = w_wr_en ? pwdata[16] : r_en_fr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
            r_ev_ch <= '0;
            r_ev_fr <= 1'b0;
            r_en_ch <= '0;
            r_en_fr <= 1'b0;
            r_ctrl  <= 2'b00;
            r_frame <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_ev_ch <= w_ev_ch_nxt;
            r_ev_fr <= w_ev_fr_nxt;
            r_en_ch <= w_en_ch_nxt;
            r_en_fr <= w_en_fr_nxt;
            if (w_wr_ctrl) begin
                r_ctrl <= pwdata[1:0];
            end
            if (w_sb_rise) begin
                r_frame <= r_frame + FRAME_W'(1);
            end
            // Evaluated on next-state flags/enables so a clear or mask
            // removes the request on the same edge that updates the flags.
            r_irq <= (|(w_ev_ch_nxt & w_en_ch_nxt)) | (w_ev_fr_nxt & w_en_fr_nxt);
        end
    end

    always_comb begin
        prdata = '0;
        if (psel) begin
            case (w_idx)
                c_idx_level:  prdata[NUM_CH-1:0] = r_level;
                c_idx_event: begin
                    prdata[NUM_CH-1:0] = r_ev_ch;
                    prdata[16]         = r_ev_fr;
                end
                c_idx_irq_en: begin
                    prdata[NUM_CH-1:0] = r_en_ch;
                    prdata[16]         = r_en_fr;
                end
                c_idx_ctrl:   prdata[1:0]         = r_ctrl;
                c_idx_frame:  prdata[FRAME_W-1:0] = r_frame;
                c_idx_sblank: prdata[0]           = r_sb_s2;
                default:      prdata              = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_navi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_navi_ctrl
// Purpose  : Directed self-checking bench for apb_navi_ctrl (NUM_CH=5,
//            DB_LIMIT=4, FRAME_W=4) with hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_navi_ctrl;

    localparam int c_NUM_CH = 5;

    logic                clk;
    logic                rst;
    logic [31:0]         paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [31:0]         pwdata;
    logic                pready;
    logic [31:0]         prdata;
    logic                pslverr;
    logic [c_NUM_CH-1:0] navi_raw;
    logic                super_blank;
    logic [c_NUM_CH-1:0] navi_level;
    logic                irq;

    int n_total = 0;
    int n_bad   = 0;

    apb_navi_ctrl #(
        .NUM_CH   (c_NUM_CH),
        .DB_CNT_W (16),
        .DB_LIMIT (4),
        .FRAME_W  (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr),
        .navi_raw    (navi_raw),
        .super_blank (super_blank),
        .navi_level  (navi_level),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Drives a full APB transfer; read data and pready are sampled on the
    // falling edge inside the access phase.
    task automatic apb_rd(input int idx, input logic [31:0] exp, input string tag);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'(idx) << 14;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk(tag, prdata, exp);
        chk({tag, "_rdy"}, {31'b0, pready}, 32'd1);
        chk({tag, "_err"}, {31'b0, pslverr}, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_wr(input int idx, input logic [31:0] data);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'(idx) << 14; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ridx[7] = '{0, 1, 2, 3, 4, 5, 7};
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; navi_raw = '0; super_blank = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("idle_prdata", prdata, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_level", {27'b0, navi_level}, 32'd0);
        foreach (ridx[i]) apb_rd(ridx[i], 32'd0, $sformatf("rst_rd%0d", ridx[i]));

        // Clean press on ch2 reaches navi_level 6 cycles after the raw edge
        apb_wr(3, 32'd1);
        apb_rd(3, 32'd1, "ctrl_rd");
        @(posedge clk); #1 navi_raw[2] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) chk("step_5cyc", {27'b0, navi_level}, 32'h0);
        @(posedge clk);
        @(negedge clk) chk("step_6cyc", {27'b0, navi_level}, 32'h4);
        chk("irq_masked", {31'b0, irq}, 32'd0);
        apb_rd(1, 32'h4, "ev_press");

        // 3-cycle glitch on ch0 is rejected
        @(posedge clk); #1 navi_raw[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 navi_raw[0] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) chk("glitch_level", {27'b0, navi_level}, 32'h4);
        apb_rd(1, 32'h4, "glitch_ev");

        // Enable, then W1C clear
        apb_wr(2, 32'h4);
        @(negedge clk) chk("irq_en", {31'b0, irq}, 32'd1);
        apb_wr(1, 32'h4);
        @(posedge clk);
        @(negedge clk) chk("irq_clr", {31'b0, irq}, 32'd0);
        apb_rd(1, 32'h0, "ev_clr");

        // Release with CTRL=1 is not captured
        #1 navi_raw[2] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) chk("rel_level", {27'b0, navi_level}, 32'h0);
        apb_rd(1, 32'h0, "ev_norel");

        // W1C coincident with a press on ch2: set wins
        @(posedge clk); #1 navi_raw[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1 psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 32'h1 << 14; pwdata = 32'h4;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        chk("coll_level", {27'b0, navi_level}, 32'h4);
        chk("coll_irq", {31'b0, irq}, 32'd1);
        apb_rd(1, 32'h4, "coll_ev");

        // CTRL=2: only release captured
        apb_wr(1, 32'h0001_FFFF);
        apb_rd(1, 32'h0, "ev_clr_all");
        apb_wr(3, 32'd2);
        @(posedge clk); #1 navi_raw[1] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk) chk("p1_level", {27'b0, navi_level}, 32'h6);
        apb_rd(1, 32'h0, "ev_nopress");
        @(posedge clk); #1 navi_raw[1] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) chk("r1_level", {27'b0, navi_level}, 32'h4);
        apb_rd(1, 32'h2, "ev_release");
        chk("irq_masked_ch1", {31'b0, irq}, 32'd0);

        // 17 super_blank pulses wrap a 4-bit FRAME to 1
        for (int p = 0; p < 17; p++) begin
            @(posedge clk); #1 super_blank = 1'b1;
            repeat (3) @(posedge clk);
            #1 super_blank = 1'b0;
            repeat (3) @(posedge clk);
        end
        repeat (4) @(posedge clk);
        apb_rd(4, 32'd1, "frame_wrap");
        apb_rd(1, 32'h0001_0002, "ev_frame");
        @(negedge clk) chk("irq_fr_masked", {31'b0, irq}, 32'd0);
        apb_wr(2, 32'hFFFF_FFFF);
        apb_rd(2, 32'h0001_001F, "irq_en_mask");
        @(negedge clk) chk("irq_frame", {31'b0, irq}, 32'd1);

        // Synchronised super_blank readback (one more frame edge)
        @(posedge clk); #1 super_blank = 1'b1;
        repeat (4) @(posedge clk);
        apb_rd(5, 32'd1, "sblank_rd");
        apb_rd(4, 32'd2, "frame_2");

        // Ignored writes and read masking
        apb_wr(7, 32'h0000_FFFF);
        apb_rd(7, 32'd0, "unmapped_rd");
        apb_wr(0, 32'h1F);
        apb_rd(0, 32'h4, "level_ro");
        apb_wr(3, 32'hFFFF_FFFF);
        apb_rd(3, 32'h3, "ctrl_mask");

        // Mid-run reset returns everything to reset values
        @(posedge clk); #1 super_blank = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst2_irq", {31'b0, irq}, 32'd0);
        chk("rst2_level", {27'b0, navi_level}, 32'd0);
        apb_rd(1, 32'd0, "rst2_ev");
        apb_rd(4, 32'd0, "rst2_frame");
        apb_rd(2, 32'd0, "rst2_en");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
